// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRAP   = 2'd1,
        RETURN = 2'd2
    } trap_state_e;

    localparam logic [3:0] CAUSE_MEI      = 4'd11;
    localparam logic [3:0] CAUSE_MTI      = 4'd7;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline/CSR-file side bundle of the trap sequencer.
interface trap_sequencer_if #(
    parameter int XLEN    = 32,
    parameter int TIMER_W = 32
);
    logic               irq_ext;
    logic               instr_valid;
    logic               is_mret;
    logic [XLEN-1:0]    pc_exe;
    logic               mstatus_mie;
    logic               mie_meie;
    logic               mie_mtie;
    logic [XLEN-1:0]    mtvec;
    logic [XLEN-1:0]    mepc;
    logic               timecmp_wr;
    logic [TIMER_W-1:0] timecmp_wdata;

    logic               trap_take;
    logic               mret_take;
    logic [XLEN-1:0]    mepc_wdata;
    logic [XLEN-1:0]    mcause_wdata;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               flush;
    logic               mtip;
    logic               meip;

    modport master (
        output irq_ext, instr_valid, is_mret, pc_exe,
        output mstatus_mie, mie_meie, mie_mtie, mtvec, mepc,
        output timecmp_wr, timecmp_wdata,
        input  trap_take, mret_take, mepc_wdata, mcause_wdata,
        input  redirect_valid, redirect_pc, flush, mtip, meip
    );

    modport slave (
        input  irq_ext, instr_valid, is_mret, pc_exe,
        input  mstatus_mie, mie_meie, mie_mtie, mtvec, mepc,
        input  timecmp_wr, timecmp_wdata,
        output trap_take, mret_take, mepc_wdata, mcause_wdata,
        output redirect_valid, redirect_pc, flush, mtip, meip
    );

endinterface

// File: rtl/machine_timer.sv
// Free-running mtime counter with mtimecmp and registered mtip compare.
module machine_timer #(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_timecmp_wr,
    input  logic [TIMER_W-1:0] i_timecmp_wdata,
    output logic               o_mtip
);

    localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

    logic [TIMER_W-1:0] r_mtime;
    logic [TIMER_W-1:0] r_mtimecmp;
    logic               r_mtip;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_mtip     <= 1'b0;
        end else begin
            r_mtime <= r_mtime + ONE;
            if (i_timecmp_wr) begin
                r_mtimecmp <= i_timecmp_wdata;
            end
            r_mtip <= (r_mtime >= r_mtimecmp);
        end
    end

    assign o_mtip = r_mtip;

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode interrupt entry and mret sequencer beside the CSR file.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMER_W = 32
) (
    input logic             clk,
    input logic             rst_n,
    trap_sequencer_if.slave bus
);

    trap_state_e r_state;
    trap_state_e w_state_nxt;

    logic            r_sync1;
    logic            r_sync2;
    logic            w_mtip;
    logic            w_pend_e;
    logic            w_pend_t;
    logic            w_take;
    logic [3:0]      w_code;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_vec_pc;
    logic [XLEN-1:0] w_trap_pc;
    logic            w_enter_trap;
    logic            w_enter_ret;
    logic [XLEN-1:0] r_mepc_wdata;
    logic [XLEN-1:0] r_mcause_wdata;
    logic [XLEN-1:0] r_redirect_pc;

    machine_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_timecmp_wr    (bus.timecmp_wr),
        .i_timecmp_wdata (bus.timecmp_wdata),
        .o_mtip          (w_mtip)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.irq_ext;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pend_e = r_sync2 & bus.mie_meie;
    assign w_pend_t = w_mtip & bus.mie_mtie;
    assign w_take   = (w_pend_e | w_pend_t) & bus.mstatus_mie;
    assign w_code   = w_pend_e ? CAUSE_MEI : CAUSE_MTI;

    // Vectored mode: base + 4*cause
    assign w_base    = {bus.mtvec[XLEN-1:2], 2'b00};
    assign w_vec_pc  = w_base + {{(XLEN-6){1'b0}}, w_code, 2'b00};
    assign w_trap_pc = (bus.mtvec[1:0] == MTVEC_VECTORED) ? w_vec_pc : w_base;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.instr_valid & bus.is_mret) begin
                    w_state_nxt = RETURN;
                end else if (bus.instr_valid & w_take) begin
                    w_state_nxt = TRAP;
                end
            end
            TRAP:    w_state_nxt = IDLE;
            RETURN:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_enter_trap = (r_state == IDLE) && (w_state_nxt == TRAP);
    assign w_enter_ret  = (r_state == IDLE) && (w_state_nxt == RETURN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mepc_wdata   <= '0;
            r_mcause_wdata <= '0;
            r_redirect_pc  <= '0;
        end else if (w_enter_trap) begin
            r_mepc_wdata   <= bus.pc_exe;
            r_mcause_wdata <= {1'b1, {(XLEN-5){1'b0}}, w_code};
            r_redirect_pc  <= w_trap_pc;
        end else if (w_enter_ret) begin
            r_redirect_pc  <= bus.mepc;
        end
    end

    assign bus.trap_take      = (r_state == TRAP);
    assign bus.mret_take      = (r_state == RETURN);
    assign bus.flush          = (r_state != IDLE);
    assign bus.redirect_valid = (r_state != IDLE);
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.mepc_wdata     = r_mepc_wdata;
    assign bus.mcause_wdata   = r_mcause_wdata;
    assign bus.mtip           = w_mtip;
    assign bus.meip           = r_sync2;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed table and sequence checks for trap_sequencer.
module tb_trap_sequencer;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    trap_sequencer_if #(.XLEN(32), .TIMER_W(32)) bus ();

    trap_sequencer #(
        .XLEN    (32),
        .TIMER_W (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic        mret;
        logic        irq;
        logic        mie;
        logic        meie;
        logic        mtie;
        logic [31:0] mtvec;
        logic [31:0] pc;
        logic [31:0] mepc;
        logic        tt;
        logic        mt;
        logic        fl;
        logic [31:0] rpc;
        logic [31:0] mepcw;
        logic [31:0] cause;
        logic        mtip;
        logic        meip;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".trap_take"}, 32'(bus.trap_take), 32'(v.tt));
        chk({tag, ".mret_take"}, 32'(bus.mret_take), 32'(v.mt));
        chk({tag, ".flush"}, 32'(bus.flush), 32'(v.fl));
        chk({tag, ".redirect_valid"}, 32'(bus.redirect_valid), 32'(v.fl));
        chk({tag, ".redirect_pc"}, bus.redirect_pc, v.rpc);
        chk({tag, ".mepc_wdata"}, bus.mepc_wdata, v.mepcw);
        chk({tag, ".mcause_wdata"}, bus.mcause_wdata, v.cause);
        chk({tag, ".mtip"}, 32'(bus.mtip), 32'(v.mtip));
        chk({tag, ".meip"}, 32'(bus.meip), 32'(v.meip));
    endtask

    vec_t tbl[20];

    initial begin
        rst_n             = 1'b0;
        bus.irq_ext       = 1'b0;
        bus.instr_valid   = 1'b0;
        bus.is_mret       = 1'b0;
        bus.pc_exe        = '0;
        bus.mstatus_mie   = 1'b0;
        bus.mie_meie      = 1'b0;
        bus.mie_mtie      = 1'b0;
        bus.mtvec         = '0;
        bus.mepc          = '0;
        bus.timecmp_wr    = 1'b0;
        bus.timecmp_wdata = '0;

        // rst iv mret irq mie meie mtie mtvec pc mepc | tt mt fl rpc mepcw cause mtip meip
        tbl[0]  = '{0,0,0,0,0,0,0,32'h0,  32'h0, 32'h0,  0,0,0,32'h0,  32'h0, 32'h0,       0,0};
        tbl[1]  = '{0,0,0,0,0,0,0,32'h0,  32'h0, 32'h0,  0,0,0,32'h0,  32'h0, 32'h0,       0,0};
        tbl[2]  = '{1,1,1,0,0,0,0,32'h0,  32'h0, 32'h44, 0,1,1,32'h44, 32'h0, 32'h0,       0,0};
        tbl[3]  = '{1,0,0,0,0,0,0,32'h0,  32'h0, 32'h44, 0,0,0,32'h44, 32'h0, 32'h0,       0,0};
        tbl[4]  = '{1,0,0,1,1,1,0,32'h100,32'h80,32'h44, 0,0,0,32'h44, 32'h0, 32'h0,       0,0};
        tbl[5]  = '{1,0,0,1,1,1,0,32'h100,32'h80,32'h44, 0,0,0,32'h44, 32'h0, 32'h0,       0,1};
        tbl[6]  = '{1,0,0,1,1,1,0,32'h100,32'h80,32'h44, 0,0,0,32'h44, 32'h0, 32'h0,       0,1};
        tbl[7]  = '{1,0,0,1,1,1,0,32'h100,32'h80,32'h44, 0,0,0,32'h44, 32'h0, 32'h0,       0,1};
        tbl[8]  = '{1,1,1,1,1,1,0,32'h100,32'h80,32'h44, 0,1,1,32'h44, 32'h0, 32'h0,       0,1};
        tbl[9]  = '{1,1,0,1,1,1,0,32'h100,32'h80,32'h44, 0,0,0,32'h44, 32'h0, 32'h0,       0,1};
        tbl[10] = '{1,1,0,1,1,1,0,32'h100,32'h80,32'h44, 1,0,1,32'h100,32'h80,32'h8000000B,0,1};
        tbl[11] = '{1,1,0,1,0,1,0,32'h100,32'h80,32'h44, 0,0,0,32'h100,32'h80,32'h8000000B,0,1};
        tbl[12] = '{1,1,0,1,0,1,0,32'h100,32'h80,32'h44, 0,0,0,32'h100,32'h80,32'h8000000B,0,1};
        tbl[13] = '{1,1,0,1,0,1,0,32'h100,32'h80,32'h44, 0,0,0,32'h100,32'h80,32'h8000000B,0,1};
        tbl[14] = '{1,1,1,1,0,1,0,32'h100,32'h80,32'h80, 0,1,1,32'h80, 32'h80,32'h8000000B,0,1};
        tbl[15] = '{1,1,0,1,1,1,0,32'h100,32'h84,32'h80, 0,0,0,32'h80, 32'h80,32'h8000000B,0,1};
        tbl[16] = '{1,1,0,1,1,1,0,32'h201,32'h84,32'h80, 1,0,1,32'h22C,32'h84,32'h8000000B,0,1};
        tbl[17] = '{1,1,0,0,0,1,0,32'h201,32'h84,32'h80, 0,0,0,32'h22C,32'h84,32'h8000000B,0,1};
        tbl[18] = '{1,1,0,0,0,1,0,32'h201,32'h84,32'h80, 0,0,0,32'h22C,32'h84,32'h8000000B,0,0};
        tbl[19] = '{1,0,1,0,0,1,0,32'h201,32'h84,32'h80, 0,0,0,32'h22C,32'h84,32'h8000000B,0,0};

        for (int i = 0; i < 20; i++) begin
            rst_n           = tbl[i].rst_n;
            bus.instr_valid = tbl[i].iv;
            bus.is_mret     = tbl[i].mret;
            bus.irq_ext     = tbl[i].irq;
            bus.mstatus_mie = tbl[i].mie;
            bus.mie_meie    = tbl[i].meie;
            bus.mie_mtie    = tbl[i].mtie;
            bus.mtvec       = tbl[i].mtvec;
            bus.pc_exe      = tbl[i].pc;
            bus.mepc        = tbl[i].mepc;
            step();
            chk_all($sformatf("row%0d", i), tbl[i]);
        end

        // Timer interrupt, direct mode: mtimecmp=20 written with reset release
        bus.is_mret = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        chk("tmr_rst.mtip", 32'(bus.mtip), 32'd0);
        rst_n             = 1'b1;
        bus.timecmp_wr    = 1'b1;
        bus.timecmp_wdata = 32'd20;
        bus.instr_valid   = 1'b1;
        bus.pc_exe        = 32'h40;
        bus.mtvec         = 32'h100;
        bus.mstatus_mie   = 1'b1;
        bus.mie_mtie      = 1'b1;
        bus.mie_meie      = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            step();
            bus.timecmp_wr = 1'b0;
            chk($sformatf("tmr%0d.mtip", k), 32'(bus.mtip), 32'(k >= 21));
            chk($sformatf("tmr%0d.trap_take", k), 32'(bus.trap_take),
                32'(k == 22));
            if (k == 22) begin
                chk("tmr.mepc_wdata", bus.mepc_wdata, 32'h40);
                chk("tmr.mcause_wdata", bus.mcause_wdata, 32'h80000007);
                chk("tmr.redirect_pc", bus.redirect_pc, 32'h100);
                chk("tmr.flush", 32'(bus.flush), 32'd1);
            end
            if (bus.trap_take) bus.mstatus_mie = 1'b0;
        end

        // Priority + bubble gating: ext and timer both pending, vectored
        bus.irq_ext     = 1'b1;
        bus.mie_meie    = 1'b1;
        bus.mstatus_mie = 1'b1;
        bus.mtvec       = 32'h201;
        bus.pc_exe      = 32'h60;
        bus.instr_valid = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk($sformatf("gate%0d.trap_take", j), 32'(bus.trap_take), 32'd0);
        end
        chk("prio.meip", 32'(bus.meip), 32'd1);
        chk("prio.mtip", 32'(bus.mtip), 32'd1);
        bus.instr_valid = 1'b1;
        step();
        chk("prio.trap_take", 32'(bus.trap_take), 32'd1);
        chk("prio.mcause_wdata", bus.mcause_wdata, 32'h8000000B);
        chk("prio.redirect_pc", bus.redirect_pc, 32'h22C);
        chk("prio.mepc_wdata", bus.mepc_wdata, 32'h60);
        bus.mstatus_mie = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk($sformatf("miegate%0d.trap_take", j), 32'(bus.trap_take),
                32'd0);
        end

        // New compare takes effect on mtip one cycle after the write edge
        bus.timecmp_wr    = 1'b1;
        bus.timecmp_wdata = 32'd1000;
        step();
        bus.timecmp_wr = 1'b0;
        chk("cmpwr.mtip_old", 32'(bus.mtip), 32'd1);
        step();
        chk("cmpwr.mtip_new", 32'(bus.mtip), 32'd0);

        bus.timecmp_wr    = 1'b1;
        bus.timecmp_wdata = 32'd3;
        step();
        bus.timecmp_wr = 1'b0;
        step();
        chk("cmp3.mtip", 32'(bus.mtip), 32'd1);

        // Abort on reset during TRAP and RETURN
        bus.mtvec       = 32'h100;
        bus.mstatus_mie = 1'b1;
        step();
        chk("abort.trap_take", 32'(bus.trap_take), 32'd1);
        rst_n           = 1'b0;
        bus.irq_ext     = 1'b0;
        bus.mstatus_mie = 1'b0;
        step();
        chk_all("abort_trap", '{0,0,0,0,0,0,0,32'h0,32'h0,32'h0,
                               0,0,0,32'h0,32'h0,32'h0,0,0});
        rst_n       = 1'b1;
        bus.is_mret = 1'b1;
        bus.mepc    = 32'h90;
        step();
        chk("abort.mret_take", 32'(bus.mret_take), 32'd1);
        bus.is_mret = 1'b0;
        rst_n       = 1'b0;
        step();
        chk("abort_ret.mret_take", 32'(bus.mret_take), 32'd0);
        chk("abort_ret.flush", 32'(bus.flush), 32'd0);
        chk("abort_ret.redirect_pc", bus.redirect_pc, 32'h0);
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            step();
            chk($sformatf("cmpreset%0d.mtip", j), 32'(bus.mtip), 32'd0);
            chk($sformatf("cmpreset%0d.flush", j), 32'(bus.flush), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Machine-mode interrupt and trap-return sequencer for the 3-stage RISC-V pipeline. It contains:
- a free-running machine timer with a compare register;
- a 2-flop synchronizer for the external interrupt line.

It watches the decoded `is_mret` flag and the execute-stage PC, and steps through a small FSM. The FSM drives pipeline flush, PC redirect, and the CSR-file write strobes for trap entry (`mepc`, `mcause`, clear MIE) and `mret` (restore MIE). It sits beside the CSR file and feeds the fetch-stage PC mux.

## Interface
Parameters:
- `XLEN`, 32, datapath/PC width
- `TIMER_W`, 32, width of `mtime`/`mtimecmp`

Ports:
- `clk`  in  1  the core clock; the block uses one clock only
- `rst_n`  in  1  reset; synchronous, active-low
- `irq_ext`  in  1  external interrupt, asynchronous level
- `instr_valid`  in  1  execute stage holds a real (non-bubble) instruction
- `is_mret`  in  1  decoded `mret` in execute stage (qualified by `instr_valid`)
- `pc_exe`  in  XLEN  PC of the execute-stage instruction
- `mstatus_mie`, `mie_meie`, `mie_mtie`  in  1 each  CSR-file enables
- `mtvec`  in  XLEN  trap vector CSR
- `mepc`  in  XLEN  current `mepc` CSR value
- `timecmp_wr`  in  1  write strobe for `mtimecmp`
- `timecmp_wdata`  in  TIMER_W  new `mtimecmp` value
- `trap_take`  out  1  one-cycle pulse; CSR file writes `mepc`/`mcause` and sets MPIE←MIE, MIE←0
- `mret_take`  out  1  one-cycle pulse; CSR file sets MIE←MPIE
- `mepc_wdata`  out  XLEN  value for `mepc`
- `mcause_wdata`  out  XLEN  value for `mcause`
- `redirect_valid`  out  1  force next PC
- `redirect_pc`  out  XLEN  target PC
- `flush`  out  1  squash fetch/execute instructions
- `mtip`  out  1  timer interrupt pending
- `meip`  out  1  synchronized external interrupt pending

## Operation
Timer:
- `mtime` increments every cycle and wraps modulo 2^TIMER_W.
- `mtip` is registered; it is 1 when `mtime >= mtimecmp` (unsigned).
- `timecmp_wr` updates `mtimecmp` on the next edge. `mtip` reflects the new compare one cycle later.

Pending logic:
- `pend_e = meip & mie_meie`; `pend_t = mtip & mie_mtie`.
- Take a trap when `(pend_e | pend_t) & mstatus_mie`.
- External has priority (code 11) over timer (code 7).
- `mcause_wdata = {1'b1, (XLEN-5)'b0, code[3:0]}`.

FSM states: IDLE, TRAP, RETURN.
- In IDLE with `instr_valid & is_mret`: go to RETURN; `mret` wins over any pending interrupt.
- Else in IDLE with `instr_valid` and a trap condition: go to TRAP.
  - Latch `mepc_wdata ← pc_exe` and the cause code.
  - The interrupted instruction is squashed and re-executed after return.
- Else stay in IDLE. Interrupts are never taken on a bubble (`instr_valid=0`).
- In TRAP (exactly 1 cycle):
  - `trap_take=1`, `flush=1`, `redirect_valid=1`.
  - `redirect_pc`: if `mtvec[1:0]==2'b01` (vectored), `{mtvec[XLEN-1:2],2'b00} + 4*code`; otherwise `{mtvec[XLEN-1:2],2'b00}`.
  - Next state is IDLE.
- In RETURN (exactly 1 cycle):
  - `mret_take=1`, `flush=1`, `redirect_valid=1`, `redirect_pc = mepc`.
  - Next state is IDLE.
- Re-entry is blocked because the CSR file clears MIE on the `trap_take` edge. IDLE therefore sees `mstatus_mie=0` on the following cycle.
- Interrupt pending while returning: it is evaluated in the first IDLE cycle after RETURN. That requires the next valid instruction and MIE restored.
- Pulse outputs (`trap_take`, `mret_take`, `flush`, `redirect_valid`) are 0 in IDLE. `mepc_wdata`, `mcause_wdata` and `redirect_pc` hold their last value when not in use.

## Timing
- All outputs are registered or decoded from the state register. No combinational path from inputs to pulse outputs.
- Reset (`rst_n=0` at a rising edge), values on that edge:
  - state IDLE;
  - `mtime=0`, `mtimecmp` all ones;
  - sync flops 0, `meip=0`, `mtip=0`;
  - all pulse outputs 0, `mepc_wdata=0`, `mcause_wdata=0`, `redirect_pc=0`.
- Reset in TRAP/RETURN aborts the sequence: no pulse appears on the next cycle.
- External latency: `irq_ext` rising before edge N gives `meip=1` after edge N+1.
- Trap latency: with `instr_valid` and enables set, TRAP is entered at edge N+2, and `trap_take`/redirect are high for cycle N+2..N+3.
- `mret` latency: `is_mret` sampled at edge N; `mret_take`/redirect are high for exactly one cycle after edge N.

## Structure
- Package `trap_pkg` holds:
  - state enum `trap_state_e` (IDLE, TRAP, RETURN);
  - cause constants `CAUSE_MEI=4'd11`, `CAUSE_MTI=4'd7`;
  - `MTVEC_VECTORED=2'b01`.
- Sub-module `machine_timer` holds the `mtime` counter, the `mtimecmp` register and the registered `mtip` compare. The synchronizer and FSM stay in the top.

## Test plan
- **Reset values:** assert `rst_n=0` for 2 cycles → all outputs at reset values, `mtip=0`; release → `mtime` counts 0,1,2.
- **Timer interrupt, direct mode:** write `mtimecmp=20`, `mie_mtie=1`, `mstatus_mie=1`, `mtvec=0x100`, `pc_exe=0x40` → when `mtime` reaches 20, one `trap_take` pulse with `mepc_wdata=0x40`, `mcause_wdata=0x80000007`, `redirect_pc=0x100`, `flush=1`.
- **Priority, vectored mode:** `irq_ext=1` and `mtip=1` together, `mtvec=0x201` → `mcause_wdata=0x8000000B`, `redirect_pc=0x22C`.
- **`mret` wins:** `is_mret=1` in the same cycle an interrupt is pending, `mepc=0x44` → `mret_take` pulse, `redirect_pc=0x44`, no `trap_take` that cycle; trap follows once MIE is restored.
- **Gating:** pending interrupt with `instr_valid=0` for 5 cycles → no trap. Then `instr_valid=1` → trap 1 cycle later. With `mstatus_mie=0` → never a trap.
- **Abort on reset:** assert reset during the TRAP cycle → no pulse on the next cycle; state IDLE; `mtimecmp` all ones.
